// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared defaults, state encoding and error word for the BNN memory sequencer
package bnn_pkg;

    localparam int BNN_ADDR_W = 6;
    localparam int BNN_DATA_W = 28;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        CAP      = 3'd2,
        SEND     = 3'd3,
        WAIT_RES = 3'd4,
        WR       = 3'd5,
        DONE     = 3'd6
    } bnn_state_t;

    // Result word written back when the core never answers.
    localparam logic [BNN_DATA_W-1:0] BNN_ERR_WORD = 28'hFFFFFFF;

endpackage

// File: rtl/bnn_feat_skid.sv
// rtl/bnn_feat_skid.sv - feature word holding register with valid/ready handshake
module bnn_feat_skid
    import bnn_pkg::*;
#(
    parameter int DATA_W = BNN_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              tready,
    output logic              tvalid,
    output logic [DATA_W-1:0] tdata,
    output logic              accept
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Capture a word from RAM and hold it, unchanged, until the core takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (valid_q && tready) begin
            valid_q <= 1'b0;
        end
    end

    // Clear masks valid in its own cycle so the core never takes a word being abandoned.
    assign tvalid = valid_q && !clr;
    assign tdata  = data_q;
    assign accept = tvalid && tready;

endmodule

// File: rtl/bnn_mem_sequencer.sv
// rtl/bnn_mem_sequencer.sv - streams RAM feature words to the BNN core, writes back its result (BNN_SEQ_TIMEOUT_EN adds a result-wait timeout)
module bnn_mem_sequencer
    import bnn_pkg::*;
#(
    parameter int ADDR_W      = BNN_ADDR_W,
    parameter int DATA_W      = BNN_DATA_W,
    parameter int NUM_IN      = 47,
    parameter int RESULT_ADDR = 47
`ifdef BNN_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iCLR,
    input  logic              iSTART,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oMEM_Rd_EN,
    output logic              oMEM_Wr_EN,
    output logic [DATA_W-1:0] oMEM_DATA,
    input  logic [DATA_W-1:0] iMEM_DATA,
    output logic              oFEAT_VALID,
    output logic [DATA_W-1:0] oFEAT_DATA,
    output logic              oFEAT_LAST,
    input  logic              iFEAT_READY,
    input  logic              iRES_VALID,
    input  logic [DATA_W-1:0] iRES_DATA,
    output logic              oBUSY,
    output logic              oDONE,
    output logic              oERR
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_IN - 1);
    localparam logic [ADDR_W-1:0] RES_ADDR = ADDR_W'(RESULT_ADDR);

    bnn_state_t        state_q;
    bnn_state_t        state_nxt;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              accept;
    logic              last_word;
    logic              timeout_hit;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              done_q;

    assign last_word = (cnt_q == LAST_IDX);

    bnn_feat_skid #(
        .DATA_W (DATA_W)
    ) u_feat_skid (
        .clk       (iCLK),
        .rst_n     (iRSTn),
        .clr       (iCLR),
        .load      (state_q == CAP),
        .load_data (iMEM_DATA),
        .tready    (iFEAT_READY),
        .tvalid    (oFEAT_VALID),
        .tdata     (oFEAT_DATA),
        .accept    (accept)
    );

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt_q;
    logic          err_q;

    assign timeout_hit = (state_q == WAIT_RES) && (tcnt_q == TW'(TIMEOUT_CYC - 1));

    // Count cycles spent waiting for the core; restarts on every entry to WAIT_RES.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            tcnt_q <= '0;
        end else if (iCLR || state_q != WAIT_RES) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // Sticky error: set on timeout, cleared only by an accepted start, reset or clear.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            err_q <= 1'b0;
        end else if (iCLR) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && iSTART) begin
            err_q <= 1'b0;
        end else if (timeout_hit && !iRES_VALID) begin
            err_q <= 1'b1;
        end
    end

    assign oERR = err_q;
`else
    assign timeout_hit = 1'b0;
    assign oERR        = 1'b0;
`endif

    // Next-state, next-counter and write-back data selection.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        wdata_nxt = iRES_DATA;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    state_nxt = RD;
                    cnt_nxt   = '0;
                end
            end
            RD:   state_nxt = CAP;
            CAP:  state_nxt = SEND;
            SEND: begin
                if (accept) begin
                    if (last_word) begin
                        state_nxt = WAIT_RES;
                    end else begin
                        state_nxt = RD;
                        cnt_nxt   = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_RES: begin
                if (iRES_VALID) begin
                    state_nxt = WR;
                end else if (timeout_hit) begin
                    state_nxt = WR;
                    wdata_nxt = DATA_W'(BNN_ERR_WORD);
                end
            end
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and RAM/done outputs, registered from the next state.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else if (iCLR) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            mem_rd_q    <= (state_nxt == RD);
            mem_wr_q    <= (state_nxt == WR);
            mem_addr_q  <= (state_nxt == RD) ? cnt_nxt :
                           (state_nxt == WR) ? RES_ADDR : '0;
            mem_wdata_q <= (state_nxt == WR) ? wdata_nxt : '0;
            done_q      <= (state_nxt == DONE);
        end
    end

    assign oMEM_ADDR  = mem_addr_q;
    assign oMEM_Rd_EN = mem_rd_q;
    assign oMEM_Wr_EN = mem_wr_q;
    assign oMEM_DATA  = mem_wdata_q;
    assign oDONE      = done_q;
    assign oBUSY      = (state_q != IDLE);
    assign oFEAT_LAST = oFEAT_VALID && last_word;

endmodule

// File: tb/tb_bnn_mem_sequencer.sv
// tb/tb_bnn_mem_sequencer.sv - directed self-checking bench for bnn_mem_sequencer
module tb_bnn_mem_sequencer;

    localparam int NUM = 47;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic        ready;
    logic        res_valid;
    logic [27:0] res_data;

    logic [5:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [27:0] mem_wdata;
    logic [27:0] mem_rdata = '0;
    logic        fv;
    logic [27:0] fd;
    logic        flast;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int bp_mode = 0;

    logic [27:0] words[$];
    int          last_cnt  = 0;
    int          last_idx  = -1;
    int          done_cnt  = 0;
    int          wr47_cnt  = 0;
    int          wr_other  = 0;
    int          both_cnt  = 0;
    int          hold_viol = 0;
    logic [27:0] ram47     = '0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [27:0] pd = '0;

    always #10 clk = ~clk;

    bnn_mem_sequencer #(
        .NUM_IN (NUM)
`ifdef BNN_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .iCLK        (clk),
        .iRSTn       (rst_n),
        .iCLR        (clr),
        .iSTART      (start),
        .oMEM_ADDR   (mem_addr),
        .oMEM_Rd_EN  (mem_rd),
        .oMEM_Wr_EN  (mem_wr),
        .oMEM_DATA   (mem_wdata),
        .iMEM_DATA   (mem_rdata),
        .oFEAT_VALID (fv),
        .oFEAT_DATA  (fd),
        .oFEAT_LAST  (flast),
        .iFEAT_READY (ready),
        .iRES_VALID  (res_valid),
        .iRES_DATA   (res_data),
        .oBUSY       (busy),
        .oDONE       (done),
        .oERR        (err)
    );

    // RAM port B (word k holds k*3, result slot at 47) and core-side monitor.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= 28'(mem_addr) * 28'd3;
        if (mem_wr) begin
            if (mem_addr == 6'd47) begin
                ram47 <= mem_wdata;
                wr47_cnt++;
            end else begin
                wr_other++;
            end
        end
        if (mem_rd && mem_wr) both_cnt++;
        if (fv && ready) begin
            words.push_back(fd);
            if (flast) begin
                last_cnt++;
                last_idx = words.size() - 1;
            end
        end
        if (pv && !pr && fv && fd !== pd) hold_viol++;
        if (done) done_cnt++;
        pv = fv;
        pr = ready;
        pd = fd;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode != 0) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_words(input int n, input int limit);
        int k = 0;
        while (words.size() < n && k < limit) begin
            tick();
            k++;
        end
        if (words.size() < n) check_eq("wait_words_timeout", words.size(), n);
    endtask

    task automatic wait_fv(input int limit);
        int k = 0;
        while (!fv && k < limit) begin
            tick();
            k++;
        end
        if (!fv) check_eq("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_done(input int limit, output int k);
        k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        if (!done) check_eq("wait_done_timeout", 0, 1);
    endtask

    task automatic send_result(input logic [27:0] val);
        res_valid = 1'b1;
        res_data  = val;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int base, input int last0);
        int errs = 0;
        for (int i = 0; i < NUM; i++) begin
            if (base + i >= words.size() || words[base + i] !== 28'(i * 3)) errs++;
        end
        check_eq({tag, "_count"}, words.size() - base, NUM);
        check_eq({tag, "_data"}, errs, 0);
        check_eq({tag, "_last_cnt"}, last_cnt - last0, 1);
        check_eq({tag, "_last_pos"}, last_idx, base + NUM - 1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ctrl"}, {fv, flast, mem_rd, mem_wr, busy, done, err}, 7'b0);
        check_eq({tag, "_addr"}, mem_addr, 6'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 28'd0);
        check_eq({tag, "_fdata"}, fd, 28'd0);
    endtask

    initial begin
        int base;
        int l0;
        int d0;
        int w0;
        int n;

        rst_n = 1'b0; clr = 1'b0; start = 1'b0; ready = 1'b0;
        res_valid = 1'b0; res_data = '0;
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // nominal stream, first-valid latency, result two cycles after the last word
        ready = 1'b1;
        base = words.size(); l0 = last_cnt; d0 = done_cnt; w0 = wr47_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!fv && n < 10) begin
            tick();
            n++;
        end
        check_eq("first_valid_lat", n, 3);
        wait_words(base + NUM, 400);
        tick();
        send_result(28'h00000A5);
        wait_done(20, n);
        tick();
        check_stream("nominal", base, l0);
        check_eq("nominal_ram47", ram47, 28'h00000A5);
        check_eq("nominal_writes", wr47_cnt - w0, 1);
        check_eq("nominal_done", done_cnt - d0, 1);
        check_eq("nominal_err", err, 1'b0);
        check_eq("nominal_busy", busy, 1'b0);

        // start-to-done latency with result present in the first WAIT_RES cycle
        base = words.size(); l0 = last_cnt; w0 = wr47_cnt;
        res_valid = 1'b1; res_data = 28'h00000C3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check_eq("start_to_done", n, 3 * NUM + 3);
        res_valid = 1'b0;
        tick();
        check_stream("latency", base, l0);
        check_eq("latency_ram47", ram47, 28'h00000C3);
        check_eq("latency_writes", wr47_cnt - w0, 1);

        // start and result pulses while streaming, start during DONE
        base = words.size(); l0 = last_cnt; w0 = wr47_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + 5, 100);
        wait_fv(10);
        start = 1'b1; res_valid = 1'b1; res_data = 28'h0000777;
        tick();
        start = 1'b0; res_valid = 1'b0;
        check_eq("ign_busy", busy, 1'b1);
        wait_words(base + NUM, 400);
        check_eq("ign_no_early_wr", wr47_cnt - w0, 0);
        tick();
        tick();
        send_result(28'h00005A5);
        wait_done(20, n);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("ign_no_restart_done", busy, 1'b0);
        tick();
        check_stream("ignored", base, l0);
        check_eq("ign_ram47", ram47, 28'h00005A5);
        check_eq("ign_writes", wr47_cnt - w0, 1);

        // random backpressure
        base = words.size(); l0 = last_cnt; w0 = wr47_cnt;
        bp_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + NUM, 2000);
        bp_mode = 0;
        ready = 1'b1;
        tick();
        send_result(28'h000001B);
        wait_done(20, n);
        tick();
        check_stream("backpressure", base, l0);
        check_eq("bp_hold", hold_viol, 0);
        check_eq("bp_ram47", ram47, 28'h000001B);

        // synchronous clear after word 10, then a fresh run
        w0 = wr47_cnt; base = words.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + 10, 100);
        ready = 1'b0;
        wait_fv(10);
        clr = 1'b1;
        #1;
        check_eq("clr_valid_drop", fv, 1'b0);
        tick();
        clr = 1'b0;
        check_idle("clr");
        ready = 1'b1;
        tick();
        check_eq("clr_no_write", wr47_cnt - w0, 0);
        base = words.size(); l0 = last_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + NUM, 400);
        tick();
        send_result(28'h000002C);
        wait_done(20, n);
        tick();
        check_stream("after_clr", base, l0);
        check_eq("after_clr_ram47", ram47, 28'h000002C);

        // asynchronous reset after word 5, then a fresh run
        w0 = wr47_cnt; base = words.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + 5, 100);
        ready = 1'b0;
        wait_fv(10);
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        check_eq("rst_no_write", wr47_cnt - w0, 0);
        base = words.size(); l0 = last_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + NUM, 400);
        tick();
        send_result(28'h000003D);
        wait_done(20, n);
        tick();
        check_stream("after_rst", base, l0);
        check_eq("after_rst_ram47", ram47, 28'h000003D);

`ifdef BNN_SEQ_TIMEOUT_EN
        // no result from the core: error word written after 16 waiting cycles
        d0 = done_cnt;
        base = words.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(base + NUM, 400);
        n = 0;
        while (!mem_wr && n < 100) begin
            tick();
            n++;
        end
        check_eq("timeout_cycles", n, 16);
        wait_done(20, n);
        check_eq("timeout_err", err, 1'b1);
        tick();
        check_eq("timeout_ram47", ram47, 28'hFFFFFFF);
        check_eq("timeout_done", done_cnt - d0, 1);
        check_eq("timeout_err_sticky", err, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("timeout_err_clear", err, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
`endif

        check_eq("rd_wr_exclusive", both_cnt, 0);
        check_eq("no_stray_writes", wr_other, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_mem_sequencer.md
Name: bnn_mem_sequencer

Overview:
- Sits between the 48x28 dual-port RAM port B and the BNN compute core, in the 50 MHz domain.
- The SPI host fills the RAM, then a start tick is generated. On that tick the block reads the input feature words in order and streams them to the core over a valid/ready handshake.
- It then waits for the core's result, writes the result back to a fixed RAM address for the host to read over SPI, and pulses done.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 28, RAM word width.
- NUM_IN, 47, number of input words streamed, from addresses 0 to NUM_IN-1. Legal range is 1 to 2^ADDR_W-1.
- RESULT_ADDR, 47, RAM address that receives the result word.
- TIMEOUT_CYC, 1024, result-wait limit. Used only when BNN_SEQ_TIMEOUT_EN is defined.

Ports:
- iCLK  in  1  single clock, CLOCK_50 domain.
- iRSTn  in  1  asynchronous active-low reset.
- iCLR  in  1  synchronous clear, active-high.
- iSTART  in  1  one-cycle start tick.
- oMEM_ADDR  out  ADDR_W  RAM port-B address.
- oMEM_Rd_EN  out  1  RAM port-B read enable.
- oMEM_Wr_EN  out  1  RAM port-B write enable.
- oMEM_DATA  out  DATA_W  RAM port-B write data.
- iMEM_DATA  in  DATA_W  RAM port-B read data. Valid one cycle after the read enable.
- oFEAT_VALID  out  1  feature word valid to the core.
- oFEAT_DATA  out  DATA_W  feature word.
- oFEAT_LAST  out  1  marks word NUM_IN-1.
- iFEAT_READY  in  1  core accepts the feature word.
- iRES_VALID  in  1  result word valid from the core.
- iRES_DATA  in  DATA_W  result word.
- oBUSY  out  1  high in every state except IDLE.
- oDONE  out  1  one-cycle completion pulse.
- oERR  out  1  sticky error flag.

Behaviour:
- Reset (iRSTn low, asynchronous):
  - All outputs go to 0.
  - State returns to IDLE, the word counter is 0, the feature register is 0.
- iCLR high at a clock edge does the same thing synchronously and overrides every other input.
- States and transitions:
  - IDLE: when iSTART is high, clear the counter, clear oERR, go to RD.
  - RD: oMEM_Rd_EN=1 and oMEM_ADDR=counter for exactly one cycle, then go to CAP.
  - CAP: latch iMEM_DATA into the feature register, then go to SEND.
  - SEND: oFEAT_VALID=1, with oFEAT_DATA held stable until acceptance. The word is accepted on a cycle where oFEAT_VALID and iFEAT_READY are both high.
    - On accept with counter=NUM_IN-1, go to WAIT_RES.
    - On accept otherwise, increment the counter and go to RD.
    - Without accept, stay in SEND.
  - WAIT_RES: on the first cycle with iRES_VALID high, latch iRES_DATA and go to WR.
  - WR: oMEM_Wr_EN=1, oMEM_ADDR=RESULT_ADDR, oMEM_DATA=latched result, for one cycle. Then go to DONE.
  - DONE: oDONE=1 for one cycle, then return to IDLE.
- oFEAT_LAST = SEND state and counter equals NUM_IN-1.
- Latency and throughput:
  - At most one feature word every 3 cycles. First oFEAT_VALID appears 3 cycles after the iSTART edge.
  - With iFEAT_READY tied high, the total from iSTART to oDONE is 3*NUM_IN + 3 cycles after the first WAIT_RES cycle in which iRES_VALID is seen.
- Read and write enables are never both high. oMEM_Rd_EN/oMEM_Wr_EN are registered outputs.
- Ignored inputs:
  - iSTART outside IDLE, including during DONE: no restart.
  - iRES_VALID outside WAIT_RES, including during streaming.
  - iFEAT_READY while oFEAT_VALID is low.
- Counter width is ADDR_W bits. It never wraps, because NUM_IN is at most 2^ADDR_W-1.
- Reset or iCLR mid-transfer:
  - Abandons the transfer and leaves no partial RAM write.
  - oFEAT_VALID drops in the same cycle for iCLR, or immediately for iRSTn.

Optional Feature:
- Macro: BNN_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RES.
  - If TIMEOUT_CYC cycles pass without iRES_VALID, set oERR (sticky until the next accepted iSTART, reset, or iCLR).
  - Then write 28'hFFFFFFF to RESULT_ADDR via WR and pulse oDONE as normal.
- Undefined: WAIT_RES waits indefinitely, oERR is tied to 0, and no timeout counter exists.

Decomposition:
- Shared package bnn_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the state encoding enum: IDLE, RD, CAP, SEND, WAIT_RES, WR, DONE;
  - the error word constant BNN_ERR_WORD = 28'hFFFFFFF.
- One sub-module, bnn_feat_skid: the feature register plus valid/ready hold logic. Everything else is flat.

Test Plan:
- Nominal run:
  - Stimulus: RAM preloaded with word k = k*3; iSTART pulse; iFEAT_READY=1; core returns 28'h00000A5 two cycles after oFEAT_LAST.
  - Required: 47 words 0,3,...,138 in order, oFEAT_LAST only on 138, RAM[47]=28'h00000A5, oDONE pulsed once, oERR=0.
- Backpressure:
  - Stimulus: iFEAT_READY toggles 0/1 pseudo-randomly.
  - Required: oFEAT_DATA stable while oFEAT_VALID=1 and iFEAT_READY=0; no word duplicated or dropped.
- Ignored inputs:
  - Stimulus: iSTART pulsed while in SEND; iRES_VALID pulsed during streaming.
  - Required: no restart, no early write, the final result is the one sent in WAIT_RES.
- Mid-transfer abort:
  - Stimulus: iCLR asserted after word 10; later, iRSTn low after word 5 of a fresh run.
  - Required: outputs return to 0, no write to address 47; a subsequent iSTART streams from word 0.
- Timeout (BNN_SEQ_TIMEOUT_EN defined):
  - Stimulus: TIMEOUT_CYC=16, no iRES_VALID.
  - Required: after 16 WAIT_RES cycles, RAM[47]=28'hFFFFFFF, oERR=1, oDONE pulses; the next iSTART clears oERR.
